// File: rtl/mp_add_sub_seq.sv
// Multi-precision add/subtract of 8*NBYTES-bit operands through one 8-bit CLA, one byte per cycle, LSB first.
// Latency: accept on edge E, out_valid rises on edge E+NBYTES; one operation per NBYTES+2 cycles at best.
// Backpressure: in_ready low in RUN/DONE; result, cout, v, zero held in DONE until out_ready.
//
// Ports: clk, rst_n (async active-low); request side in_valid/in_ready/sub/cin/x/y;
//        result side out_valid/out_ready/result/cout/v, plus zero when MP_ADD_SUB_SEQ_ZERO_EN is defined.
// Optional feature macro: MP_ADD_SUB_SEQ_ZERO_EN (sticky all-zero result flag on port zero).

// 8-bit carry look-ahead adder-subtractor: s = a + (b ^ {8{sub}}) + (cin | sub).
// Every carry is expanded as a flat generate/propagate sum of products from the byte carry-in.
module claAddSub8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       v
);
    logic [7:0] bb;
    logic [7:0] g;
    logic [7:0] p;
    logic       c0;
    logic [8:1] c;
    logic       acc;
    logic       term;

    always_comb begin
        bb   = b ^ {8{sub}};
        g    = a & bb;
        p    = a ^ bb;
        c0   = cin | sub;
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // carry-in propagated through bits 0..i
            acc = c0;
            for (int k = 0; k <= i; k++) begin
                acc = acc & p[k];
            end
            // generate at bit j propagated through bits j+1..i
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        s    = p ^ {c[7:1], c0};
        cout = c[8];
        // signed overflow: carry into the MSB differs from carry out of it
        v    = c[8] ^ c[7];
    end
endmodule

module mp_add_sub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sub,
    input  logic                cin,
    input  logic [8*NBYTES-1:0] x,
    input  logic [8*NBYTES-1:0] y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                v
`ifdef MP_ADD_SUB_SEQ_ZERO_EN
   ,output logic                zero
`endif
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic            carry_q,  carry_d;
    logic [W-1:0]    x_q,      x_d;
    logic [W-1:0]    y_q,      y_d;     // already XORed with sub at accept
    logic [W-1:0]    result_q, result_d;
    logic            cout_q,   cout_d;
    logic            v_q,      v_d;

    logic [7:0]      add_a;
    logic [7:0]      add_b;
    logic [7:0]      add_s;
    logic            add_cout;
    logic            add_v;

    // Subtraction is fully encoded at accept (inverted y, carry forced to 1),
    // so the shared adder always runs in add mode.
    claAddSub8 u_cla (
        .a    (add_a),
        .b    (add_b),
        .sub  (1'b0),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_cout),
        .v    (add_v)
    );

    always_comb begin
        add_a = x_q[idx_q*8 +: 8];
        add_b = y_q[idx_q*8 +: 8];
    end

`ifdef MP_ADD_SUB_SEQ_ZERO_EN
    logic zero_q, zero_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        cout_d   = cout_q;
        v_d      = v_q;
`ifdef MP_ADD_SUB_SEQ_ZERO_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y ^ {W{sub}};
                    carry_d = sub | cin;
                    idx_d   = '0;
`ifdef MP_ADD_SUB_SEQ_ZERO_EN
                    zero_d  = 1'b1;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*8 +: 8] = add_s;
                carry_d                = add_cout;
`ifdef MP_ADD_SUB_SEQ_ZERO_EN
                zero_d                 = zero_q & (add_s == 8'h00);
`endif
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    v_d     = add_v;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            v_q      <= v_d;
        end
    end

`ifdef MP_ADD_SUB_SEQ_ZERO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign v         = v_q;
endmodule
